// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_unit
// Purpose  : In-order instruction fetch front end with a PC-tagged prefetch
//            queue, branch redirect/discard and HLT detection.
// Revision : 1.0
// ============================================================================
module fetch_prefetch_unit #(
    parameter int               ADDR_W   = 16,
    parameter int               INSTR_W  = 16,
    parameter int               DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int               PC_STEP  = 2,
    parameter logic [3:0]       HALT_OP  = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_rsp_valid,
    input  logic [INSTR_W-1:0] mem_rsp_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);

    localparam int            c_CW    = $clog2(DEPTH + 1);
    localparam int            c_PW    = $clog2(DEPTH);
    localparam logic [c_CW:0] c_DEPTH = (c_CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_STOP   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [c_CW-1:0]     inflight_q, inflight_d;
    logic [c_CW-1:0]     drop_q, drop_d;
    logic [c_CW-1:0]     count_q, count_d;
    logic [c_PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [c_PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [INSTR_W-1:0]  data_q [DEPTH];
    logic [ADDR_W-1:0]   tag_q  [DEPTH];

    logic [c_CW:0]       w_credit;
    logic                w_fire;
    logic                w_rsp_keep;
    logic                w_deq;
    logic                w_rsp_halt;
    logic                w_head_halt;
    logic [c_CW-1:0]     w_pending;
    logic [ADDR_W-1:0]   w_rsp_tag;

    // Credit check counts both queued and in-flight entries, so every
    // response is guaranteed a free slot.
    assign w_credit      = {1'b0, inflight_q} + {1'b0, count_q};
    assign mem_req_valid = !rst && (state_q == S_RUN) && (w_credit < c_DEPTH) && !redirect;
    assign mem_req_addr  = pc_q;
    assign pc            = pc_q;
    assign halted        = (state_q == S_HALTED);

    assign out_valid = (count_q != '0);
    assign out_instr = data_q[rd_ptr_q];
    assign out_pc    = tag_q[rd_ptr_q];

    assign w_fire      = mem_req_valid && mem_req_ready;
    assign w_rsp_keep  = mem_rsp_valid && (drop_q == '0) && (state_q != S_HALTED) && !redirect;
    assign w_deq       = out_valid && out_ready && !redirect;
    assign w_rsp_halt  = (mem_rsp_data[INSTR_W-1 -: 4] == HALT_OP);
    assign w_head_halt = (out_instr[INSTR_W-1 -: 4] == HALT_OP);

    // Surviving in-flight fetches were issued contiguously since the last
    // redirect, so the oldest one sits (inflight - drop) steps behind pc.
    assign w_pending = inflight_q - drop_q;
    assign w_rsp_tag = pc_q - ADDR_W'(w_pending) * ADDR_W'(PC_STEP);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        inflight_d = inflight_q + c_CW'(w_fire) - c_CW'(mem_rsp_valid);
        count_d    = count_q + c_CW'(w_rsp_keep) - c_CW'(w_deq);

        if (w_fire) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
        if (mem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
        if (w_rsp_keep) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case (state_q)
            S_RUN: begin
                if (w_rsp_keep && w_rsp_halt) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                state_d = S_STOP;
            end
            default: begin
                state_d = S_HALTED;
            end
        endcase

        if (w_deq && w_head_halt && (state_q != S_HALTED)) begin
            state_d  = S_HALTED;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end

        if (redirect && (state_q != S_HALTED)) begin
            state_d  = S_RUN;
            pc_d     = redirect_pc;
            drop_d   = inflight_d;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rsp_keep) begin
            data_q[wr_ptr_q] <= mem_rsp_data;
            tag_q[wr_ptr_q]  <= w_rsp_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// Bench for fetch_prefetch_unit: behavioural memory with configurable latency
// and a scoreboard of {pc, instr} expected at the decode side.
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [15:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [15:0] mem_rsp_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic        out_ready;
    logic [15:0] pc;
    logic        halted;

    fetch_prefetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_ready    (out_ready),
        .pc           (pc),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          due;
    } mreq_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    int          lat   = 1;
    int          cyc   = 0;
    int          outstanding = 0;
    int          max_out = 0;
    logic        halt_next = 1'b0;
    logic        halted_m  = 1'b0;
    mreq_t       mq[$];
    exp_t        sb[$];
    logic [15:0] issued[$];
    logic [15:0] consumed[$];
    logic [15:0] prog[logic [15:0]];

    function automatic logic [15:0] imem(input logic [15:0] a);
        if (prog.exists(a)) return prog[a];
        return {4'h1, a[11:0]};
    endfunction

    // One clock cycle: drive memory at negedge, observe just before posedge.
    task automatic step();
        mreq_t m;
        exp_t  e;
        logic [15:0] op;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 16'h0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = m.data;
            outstanding--;
        end
        #1;
        if (lat == 0 && !mem_rsp_valid && mem_req_valid && mem_req_ready) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = imem(mem_req_addr);
        end
        #3;
        if (out_valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL stale_out: out_pc=%h out_instr=%h visible, required no valid output", out_pc, out_instr);
            end else if (out_pc !== sb[0].pc || out_instr !== sb[0].instr) begin
                fails++;
                $display("FAIL head: got pc=%h instr=%h, required pc=%h instr=%h",
                         out_pc, out_instr, sb[0].pc, sb[0].instr);
            end
        end
        if (redirect && !halted_m) begin
            sb.delete();
        end else if (out_valid && out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            consumed.push_back(e.pc);
            op = e.instr;
            if (op[15:12] == 4'hF) begin
                halt_next = 1'b1;
                sb.delete();
            end
        end
        if (mem_req_valid && mem_req_ready) begin
            e.pc    = mem_req_addr;
            e.instr = imem(mem_req_addr);
            sb.push_back(e);
            issued.push_back(mem_req_addr);
            if (lat != 0) begin
                mq.push_back('{addr: mem_req_addr, data: imem(mem_req_addr), due: cyc + lat});
                outstanding++;
                if (outstanding > max_out) max_out = outstanding;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (halt_next) begin
            halt_next = 1'b0;
            halted_m  = 1'b1;
            tests++;
            if (halted !== 1'b1) begin
                fails++;
                $display("FAIL halt_timing: halted=%b one cycle after HLT consumed, required 1", halted);
            end
        end
    endtask

    task automatic clear_model();
        mq.delete();
        sb.delete();
        issued.delete();
        consumed.delete();
        outstanding = 0;
        halt_next   = 1'b0;
        halted_m    = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 16'h0;
        out_ready     = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("reset_pc", pc, 16'h0000);
        chk("reset_out_valid", {15'b0, out_valid}, 16'h0);
        chk("reset_req_valid", {15'b0, mem_req_valid}, 16'h0);
        chk("reset_halted", {15'b0, halted}, 16'h0);
        do_reset();
    endtask

    task automatic test_program();
        do_reset();
        prog.delete();
        prog[16'h0000] = 16'h1123;
        prog[16'h0002] = 16'h2234;
        prog[16'h0004] = 16'hF000;
        lat = 0;
        mem_req_ready = 1'b1;
        out_ready     = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("prog_issue_count", 16'(issued.size()), 16'd3);
        chk("prog_consumed_count", 16'(consumed.size()), 16'd3);
        if (consumed.size() == 3) begin
            chk("prog_pc0", consumed[0], 16'h0000);
            chk("prog_pc1", consumed[1], 16'h0002);
            chk("prog_pc2", consumed[2], 16'h0004);
        end
        chk("prog_halted", {15'b0, halted}, 16'h1);
        chk("prog_no_req_halted", {15'b0, mem_req_valid}, 16'h0);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_clears_halted", {15'b0, halted}, 16'h0);
        lat = 1;
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        prog.delete();
        lat = 3;
        mem_req_ready = 1'b1;
        out_ready     = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk("bp_issue_count", 16'(issued.size()), 16'd4);
        if (issued.size() == 4) chk("bp_last_addr", issued[3], 16'h0006);
        chk("bp_req_stalled", {15'b0, mem_req_valid}, 16'h0);
        chk("bp_out_valid", {15'b0, out_valid}, 16'h1);
        n = issued.size();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        tests++;
        if (issued.size() <= n) begin
            fails++;
            $display("FAIL bp_resume: issued %0d requests, required more than %0d", issued.size(), n);
        end else begin
            chk("bp_resume_addr", issued[n], 16'h0008);
        end
    endtask

    task automatic test_redirect();
        int n;
        do_reset();
        prog.delete();
        lat = 3;
        mem_req_ready = 1'b1;
        out_ready     = 1'b1;
        step();
        step();
        chk("redir_inflight", 16'(mq.size()), 16'd2);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        n = consumed.size();
        for (int i = 0; i < 15; i++) step();
        tests++;
        if (consumed.size() <= n) begin
            fails++;
            $display("FAIL redir_first: consumed %0d, required at least %0d", consumed.size(), n + 1);
        end else begin
            chk("redir_first_pc", consumed[n], 16'h0040);
        end
    endtask

    task automatic test_halt_redirect();
        int n;
        int c;
        do_reset();
        prog.delete();
        prog[16'h0010] = 16'hF000;
        lat = 1;
        mem_req_ready = 1'b1;
        out_ready     = 1'b0;
        redirect      = 1'b1;
        redirect_pc   = 16'h0010;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("hr_stop_no_req", {15'b0, mem_req_valid}, 16'h0);
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        step();
        redirect = 1'b0;
        n = issued.size();
        c = consumed.size();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("hr_halted_low", {15'b0, halted}, 16'h0);
        tests++;
        if (issued.size() <= n || consumed.size() <= c) begin
            fails++;
            $display("FAIL hr_resume: issued %0d consumed %0d, required fetch to continue", issued.size(), consumed.size());
        end else begin
            chk("hr_resume_addr", issued[n], 16'h0020);
            chk("hr_resume_pc", consumed[c], 16'h0020);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        prog.delete();
        lat = 1;
        mem_req_ready = 1'b0;
        out_ready     = 1'b1;
        redirect      = 1'b1;
        redirect_pc   = 16'hFFFE;
        step();
        redirect = 1'b0;
        chk("wrap_pc_start", pc, 16'hFFFE);
        mem_req_ready = 1'b1;
        step();
        chk("wrap_pc_after", pc, 16'h0000);
        for (int i = 0; i < 6; i++) step();
        tests++;
        if (consumed.size() < 2) begin
            fails++;
            $display("FAIL wrap_count: consumed %0d, required at least 2", consumed.size());
        end else begin
            chk("wrap_tag0", consumed[0], 16'hFFFE);
            chk("wrap_tag1", consumed[1], 16'h0000);
        end
    endtask

    task automatic test_async_reset();
        int i;
        do_reset();
        prog.delete();
        lat = 3;
        mem_req_ready = 1'b1;
        out_ready     = 1'b0;
        i = 0;
        while (!(issued.size() == 4 && mq.size() == 1) && i < 20) begin
            step();
            i++;
        end
        tests++;
        if (i >= 20) begin
            fails++;
            $display("FAIL ar_setup: issued %0d pending %0d, required 4 and 1", issued.size(), mq.size());
        end
        chk("ar_pre_out_valid", {15'b0, out_valid}, 16'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", {15'b0, out_valid}, 16'h0);
        chk("ar_pc", pc, 16'h0000);
        chk("ar_halted", {15'b0, halted}, 16'h0);
        chk("ar_req_valid", {15'b0, mem_req_valid}, 16'h0);
        clear_model();
    endtask

    task automatic test_counters();
        tests++;
        if (max_out > 4) begin
            fails++;
            $display("FAIL inflight_bound: max outstanding %0d, required at most 4", max_out);
        end
    endtask

    initial begin
        rst           = 1'b1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 16'h0;
        redirect      = 1'b0;
        redirect_pc   = 16'h0;
        out_ready     = 1'b0;
        test_reset();
        test_program();
        test_backpressure();
        test_redirect();
        test_halt_redirect();
        test_wrap();
        test_async_reset();
        test_counters();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
